// File: rtl/tlb_mp_if.sv
`default_nettype none
// ============================================================================
// Module      : tlb_mp_if
// Description : Bundle of the tlb_mp search, write/read, INVTLB and counter
//               signals. The master modport drives requests (CPU side);
//               the slave modport is the TLB itself.
//               Search:  s_req, s_key -> s_rvalid, s_found, s_index, s_res
//               Write:   we, w_index, w_entry
//               Read:    r_index -> r_entry
//               TLBFILL: fill_idx
//               INVTLB:  inv_valid/inv_ready, inv_op, inv_key -> inv_done, inv_err
//               Perf:    hit_cnt, miss_cnt
// Revision    : 1.0 - initial release
// ============================================================================
interface tlb_mp_if #(
    parameter int TLBNUM = 16,
    parameter int NPORT  = 2
);
    localparam int IDXW = $clog2(TLBNUM);

    logic [NPORT-1:0]      s_req;
    logic [NPORT*30-1:0]   s_key;
    logic [NPORT-1:0]      s_rvalid;
    logic [NPORT-1:0]      s_found;
    logic [NPORT*IDXW-1:0] s_index;
    logic [NPORT*32-1:0]   s_res;

    logic                  we;
    logic [IDXW-1:0]       w_index;
    logic [88:0]           w_entry;
    logic [IDXW-1:0]       r_index;
    logic [88:0]           r_entry;
    logic [IDXW-1:0]       fill_idx;

    logic                  inv_valid;
    logic                  inv_ready;
    logic [4:0]            inv_op;
    logic [28:0]           inv_key;
    logic                  inv_done;
    logic                  inv_err;

    logic [31:0]           hit_cnt;
    logic [31:0]           miss_cnt;

    modport master (
        output s_req, s_key, we, w_index, w_entry, r_index,
               inv_valid, inv_op, inv_key,
        input  s_rvalid, s_found, s_index, s_res, r_entry, fill_idx,
               inv_ready, inv_done, inv_err, hit_cnt, miss_cnt
    );

    modport slave (
        input  s_req, s_key, we, w_index, w_entry, r_index,
               inv_valid, inv_op, inv_key,
        output s_rvalid, s_found, s_index, s_res, r_entry, fill_idx,
               inv_ready, inv_done, inv_err, hit_cnt, miss_cnt
    );
endinterface : tlb_mp_if
`default_nettype wire

// File: rtl/tlb_mp.sv
`default_nettype none
// ============================================================================
// Module      : tlb_mp
// Description : Fully associative TLB with NPORT registered search ports,
//               one write port, a combinational read port, a free-running
//               TLBFILL index and a sequential INVTLB walker.
// Ports       : clk     - clock, rising edge
//               resetn  - asynchronous active-low reset
//               bus     - tlb_mp_if.slave (search/write/read/INVTLB/perf)
// Config      : TLB_PERF_CNT_EN - when defined, saturating hit/miss counters
//               are built; otherwise hit_cnt/miss_cnt are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module tlb_mp #(
    parameter int TLBNUM = 16,
    parameter int NPORT  = 2,
    parameter int PS_BIG = 21
) (
    input  logic      clk,
    input  logic      resetn,
    tlb_mp_if.slave   bus
);
    localparam int         IDXW       = $clog2(TLBNUM);
    localparam logic [5:0] c_PS_BIG   = 6'(PS_BIG);
    localparam logic [5:0] c_PS_SMALL = 6'd12;
    localparam logic [IDXW-1:0] c_LAST = IDXW'(TLBNUM - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WALK = 2'd1,
        DONE = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Entry storage. Each half is {ppn[19:0], plv[1:0], mat[1:0], d, v}.
    // Only the e bits are reset; the remaining fields are don't-care
    // until written.
    // ------------------------------------------------------------------
    logic        r_e     [TLBNUM];
    logic [18:0] r_vppn  [TLBNUM];
    logic        r_huge  [TLBNUM];
    logic [9:0]  r_asid  [TLBNUM];
    logic        r_g     [TLBNUM];
    logic [25:0] r_half0 [TLBNUM];
    logic [25:0] r_half1 [TLBNUM];

    state_t          r_state;
    state_t          w_state_nxt;
    logic [4:0]      r_op;
    logic [28:0]     r_key;
    logic [IDXW-1:0] r_ctr;
    logic [IDXW-1:0] r_fill;
    logic            w_inv_ready;
    logic            w_inv_done;
    logic            w_inv_err;
    logic            w_inv_sel;

    // Write-port field split
    logic        w_wr_e;
    logic [18:0] w_wr_vppn;
    logic [5:0]  w_wr_ps;
    logic [9:0]  w_wr_asid;
    logic        w_wr_g;
    logic [25:0] w_wr_h0;
    logic [25:0] w_wr_h1;

    assign w_wr_e    = bus.w_entry[88];
    assign w_wr_vppn = bus.w_entry[87:69];
    assign w_wr_ps   = bus.w_entry[68:63];
    assign w_wr_asid = bus.w_entry[62:53];
    assign w_wr_g    = bus.w_entry[52];
    assign w_wr_h0   = bus.w_entry[51:26];
    assign w_wr_h1   = bus.w_entry[25:0];

    always_ff @(posedge clk) begin
        if (bus.we) begin
            r_vppn[bus.w_index]  <= w_wr_vppn;
            r_huge[bus.w_index]  <= (w_wr_ps == c_PS_BIG);
            r_asid[bus.w_index]  <= w_wr_asid;
            r_g[bus.w_index]     <= w_wr_g;
            r_half0[bus.w_index] <= w_wr_h0;
            r_half1[bus.w_index] <= w_wr_h1;
        end
    end

    // The write is placed after the walker clear so that a same-cycle
    // write to the entry under invalidation wins.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < TLBNUM; i++) begin
                r_e[i] <= 1'b0;
            end
        end else begin
            if (r_state == WALK && w_inv_sel) begin
                r_e[r_ctr] <= 1'b0;
            end
            if (bus.we) begin
                r_e[bus.w_index] <= w_wr_e;
            end
        end
    end

    assign bus.r_entry = {r_e[bus.r_index], r_vppn[bus.r_index],
                          (r_huge[bus.r_index] ? c_PS_BIG : c_PS_SMALL),
                          r_asid[bus.r_index], r_g[bus.r_index],
                          r_half0[bus.r_index], r_half1[bus.r_index]};

    // ------------------------------------------------------------------
    // Search ports
    // ------------------------------------------------------------------
    logic [NPORT-1:0]      w_rvalid_v;
    logic [NPORT-1:0]      w_found_v;
    logic [NPORT*IDXW-1:0] w_index_v;
    logic [NPORT*32-1:0]   w_res_v;

    for (genvar p = 0; p < NPORT; p++) begin : g_port
        logic [18:0]       w_kvppn;
        logic              w_kodd;
        logic [9:0]        w_kasid;
        logic [TLBNUM-1:0] w_hit;
        logic              w_found;
        logic [IDXW-1:0]   w_idx;
        logic              w_odd;
        logic [25:0]       w_half;
        logic [31:0]       w_res;
        logic              r_rvalid;
        logic              r_found;
        logic [IDXW-1:0]   r_idx;
        logic [31:0]       r_res;

        assign w_kvppn = bus.s_key[p*30+11 +: 19];
        assign w_kodd  = bus.s_key[p*30+10];
        assign w_kasid = bus.s_key[p*30 +: 10];

        always_comb begin
            for (int i = 0; i < TLBNUM; i++) begin
                w_hit[i] = r_e[i]
                        && (r_vppn[i][18:9] == w_kvppn[18:9])
                        && (r_huge[i] || (r_vppn[i][8:0] == w_kvppn[8:0]))
                        && (r_g[i] || (r_asid[i] == w_kasid));
            end
        end

        // Scan downward so the lowest matching index is the last assignment.
        always_comb begin
            w_found = 1'b0;
            w_idx   = '0;
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (w_hit[i]) begin
                    w_found = 1'b1;
                    w_idx   = IDXW'(i);
                end
            end
        end

        // Huge pages pick the half by vppn[8] because bit 12 is inside the page.
        assign w_odd  = r_huge[w_idx] ? w_kvppn[8] : w_kodd;
        assign w_half = w_odd ? r_half1[w_idx] : r_half0[w_idx];
        assign w_res  = w_found ? {w_half[25:6],
                                   (r_huge[w_idx] ? c_PS_BIG : c_PS_SMALL),
                                   w_half[5:0]} : 32'd0;

        always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
                r_rvalid <= 1'b0;
                r_found  <= 1'b0;
                r_idx    <= '0;
                r_res    <= '0;
            end else begin
                r_rvalid <= bus.s_req[p];
                if (bus.s_req[p]) begin
                    r_found <= w_found;
                    r_idx   <= w_idx;
                    r_res   <= w_res;
                end
            end
        end

        assign w_rvalid_v[p]               = r_rvalid;
        assign w_found_v[p]                = r_found;
        assign w_index_v[p*IDXW +: IDXW]   = r_idx;
        assign w_res_v[p*32 +: 32]         = r_res;
    end

    assign bus.s_rvalid = w_rvalid_v;
    assign bus.s_found  = w_found_v;
    assign bus.s_index  = w_index_v;
    assign bus.s_res    = w_res_v;

    // ------------------------------------------------------------------
    // TLBFILL index: free-running, wraps naturally since TLBNUM is 2^n
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fill <= '0;
        end else begin
            r_fill <= r_fill + IDXW'(1);
        end
    end
    assign bus.fill_idx = r_fill;

    // ------------------------------------------------------------------
    // INVTLB walker
    // ------------------------------------------------------------------
    logic [18:0] w_inv_vppn;
    logic [9:0]  w_inv_asid;
    logic        w_asid_eq;
    logic        w_vppn_eq;

    assign w_inv_vppn = r_key[28:10];
    assign w_inv_asid = r_key[9:0];
    assign w_asid_eq  = (r_asid[r_ctr] == w_inv_asid);
    assign w_vppn_eq  = r_huge[r_ctr] ? (r_vppn[r_ctr][18:9] == w_inv_vppn[18:9])
                                      : (r_vppn[r_ctr] == w_inv_vppn);

    always_comb begin
        w_inv_sel = 1'b0;
        case (r_op)
            5'd0, 5'd1: w_inv_sel = 1'b1;
            5'd2:       w_inv_sel = r_g[r_ctr];
            5'd3:       w_inv_sel = !r_g[r_ctr];
            5'd4:       w_inv_sel = !r_g[r_ctr] && w_asid_eq;
            5'd5:       w_inv_sel = !r_g[r_ctr] && w_asid_eq && w_vppn_eq;
            5'd6:       w_inv_sel = (r_g[r_ctr] || w_asid_eq) && w_vppn_eq;
            default:    w_inv_sel = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_inv_ready = 1'b0;
        w_inv_done  = 1'b0;
        w_inv_err   = 1'b0;
        case (r_state)
            IDLE: begin
                w_inv_ready = 1'b1;
                if (bus.inv_valid) begin
                    // Illegal ops bypass the walk so no entry is touched
                    w_state_nxt = (bus.inv_op > 5'd6) ? DONE : WALK;
                end
            end
            WALK: begin
                if (r_ctr == c_LAST) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_inv_done  = 1'b1;
                w_inv_err   = (r_op > 5'd6);
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_op  <= '0;
            r_key <= '0;
            r_ctr <= '0;
        end else if (w_inv_ready && bus.inv_valid) begin
            r_op  <= bus.inv_op;
            r_key <= bus.inv_key;
            r_ctr <= '0;
        end else if (r_state == WALK) begin
            r_ctr <= r_ctr + IDXW'(1);
        end
    end

    assign bus.inv_ready = w_inv_ready;
    assign bus.inv_done  = w_inv_done;
    assign bus.inv_err   = w_inv_err;

    // ------------------------------------------------------------------
    // Performance counters
    // ------------------------------------------------------------------
`ifdef TLB_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;
    logic [2:0]  w_hit_inc;
    logic [2:0]  w_miss_inc;
    logic [32:0] w_hit_sum;
    logic [32:0] w_miss_sum;

    always_comb begin
        w_hit_inc  = 3'd0;
        w_miss_inc = 3'd0;
        for (int p = 0; p < NPORT; p++) begin
            w_hit_inc  = w_hit_inc  + {2'b00, w_rvalid_v[p] &  w_found_v[p]};
            w_miss_inc = w_miss_inc + {2'b00, w_rvalid_v[p] & !w_found_v[p]};
        end
    end

    assign w_hit_sum  = {1'b0, r_hit_cnt}  + {30'd0, w_hit_inc};
    assign w_miss_sum = {1'b0, r_miss_cnt} + {30'd0, w_miss_inc};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_hit_cnt  <= w_hit_sum[32]  ? 32'hFFFF_FFFF : w_hit_sum[31:0];
            r_miss_cnt <= w_miss_sum[32] ? 32'hFFFF_FFFF : w_miss_sum[31:0];
        end
    end

    assign bus.hit_cnt  = r_hit_cnt;
    assign bus.miss_cnt = r_miss_cnt;
`else
    assign bus.hit_cnt  = 32'd0;
    assign bus.miss_cnt = 32'd0;
`endif

endmodule : tlb_mp
`default_nettype wire
